// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_DONE
  } state_e;

  localparam logic [1:0]  MemctrlIdle = 2'b00;
  localparam logic [1:0]  MemctrlIF   = 2'b01;
  localparam logic [1:0]  MemctrlMem  = 2'b10;
  localparam logic [1:0]  IoAddrHi    = 2'b11;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Loads encode a byte count, stores encode the last byte index; both become a count of 1..4.
  function automatic logic [2:0] byte_count(input logic is_store, input logic [2:0] len);
    if (is_store) return (len >= 3'd3) ? 3'd4 : len + 3'd1;
    if (len >= 3'd4) return 3'd4;
    if (len == 3'd0) return 3'd1;
    return len;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and mem-stage requests onto an 8-bit RAM/IO bus, one byte per cycle,
// assembling and splitting little-endian words.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IoAddrHi
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_inst_out,
  input  logic        read_req_in,
  input  logic        write_req_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_val_in,
  input  logic [2:0]  store_len_in,
  output logic        mem_done_out,
  output logic [31:0] mem_val_read_out,
  output logic [1:0]  busy_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_e      state_q;
  logic [31:0] addr_q, data_q, asm_q, mem_a_q, if_inst_q, mem_val_q;
  logic [31:0] asm_d, next_a_d;
  logic [2:0]  n_q, k_q, k_d;
  logic [1:0]  busy_q, cap_j;
  logic [7:0]  mem_dout_q, next_byte_d;
  logic        wr_q, if_done_q, mem_done_q;
  logic        mem_req, acc_mem, acc_if, io_sel, stall;

  always_comb begin
    mem_req     = read_req_in | write_req_in;
    acc_mem     = mem_req && (state_q == ST_IDLE || state_q == ST_IF_RD);
    acc_if      = if_req_in && !mem_req && (state_q == ST_IDLE);
    io_sel      = (addr_q[17:16] == IO_ADDR_HI);
    stall       = io_sel && io_buffer_full;
    k_d         = k_q + 3'd1;
    next_a_d    = addr_q + {29'd0, k_d};
    next_byte_d = data_q[{k_d[1:0], 3'b000} +: 8];
    // mem_din holds the byte addressed one cycle earlier, i.e. index k-1.
    cap_j       = k_q[1:0] - 2'd1;
    asm_d       = asm_q;
    if (k_q != 3'd0) asm_d[{cap_j, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      busy_q     <= MemctrlIdle;
      k_q        <= 3'd0;
      wr_q       <= 1'b0;
      mem_a_q    <= ZeroWord;
      mem_dout_q <= 8'h00;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_inst_q  <= ZeroWord;
      mem_val_q  <= ZeroWord;
    end else if (acc_mem || acc_if) begin
      // A mem request arriving during a fetch takes over here; the partial word is dropped.
      addr_q     <= acc_mem ? mem_addr_in : if_addr_in;
      mem_a_q    <= acc_mem ? mem_addr_in : if_addr_in;
      data_q     <= mem_val_in;
      n_q        <= acc_mem ? byte_count(write_req_in, store_len_in) : 3'd4;
      k_q        <= 3'd0;
      asm_q      <= ZeroWord;
      mem_dout_q <= (acc_mem && write_req_in) ? mem_val_in[7:0] : 8'h00;
      wr_q       <= acc_mem && write_req_in;
      busy_q     <= acc_mem ? MemctrlMem : MemctrlIF;
      state_q    <= acc_if ? ST_IF_RD : (write_req_in ? ST_MEM_WR : ST_MEM_RD);
    end else begin
      case (state_q)
        ST_IF_RD, ST_MEM_RD: begin
          asm_q <= asm_d;
          if (k_q == n_q) begin
            state_q <= ST_DONE;
            busy_q  <= MemctrlIdle;
            mem_a_q <= ZeroWord;
            if (state_q == ST_IF_RD) begin
              if_done_q <= 1'b1;
              if_inst_q <= asm_d;
            end else begin
              mem_done_q <= 1'b1;
              mem_val_q  <= asm_d;
            end
          end else begin
            k_q     <= k_d;
            mem_a_q <= (k_d < n_q) ? next_a_d : ZeroWord;
          end
        end
        ST_MEM_WR: begin
          if (!stall) begin
            if (k_d == n_q) begin
              state_q    <= ST_DONE;
              busy_q     <= MemctrlIdle;
              wr_q       <= 1'b0;
              mem_a_q    <= ZeroWord;
              mem_dout_q <= 8'h00;
              mem_done_q <= 1'b1;
            end else begin
              k_q        <= k_d;
              mem_a_q    <= next_a_d;
              mem_dout_q <= next_byte_d;
            end
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // IO-full gates the strobe in the same cycle so a stalled byte never reaches the bus.
  assign mem_wr           = wr_q & ~stall;
  assign mem_a            = mem_a_q;
  assign mem_dout         = mem_dout_q;
  assign busy_out         = busy_q;
  assign if_done_out      = if_done_q;
  assign if_inst_out      = if_inst_q;
  assign mem_done_out     = mem_done_q;
  assign mem_val_read_out = mem_val_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized bench for mem_ctrl with a byte-array RAM and a transaction-level reference.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, if_req_in, read_req_in, write_req_in, io_buffer_full;
  logic [31:0] if_addr_in, mem_addr_in, mem_val_in;
  logic [2:0]  store_len_in;
  logic [7:0]  mem_din;
  logic        if_done_out, mem_done_out, mem_wr;
  logic [31:0] if_inst_out, mem_val_read_out, mem_a;
  logic [1:0]  busy_out;
  logic [7:0]  mem_dout;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done_out), .if_inst_out(if_inst_out),
    .read_req_in(read_req_in), .write_req_in(write_req_in),
    .mem_addr_in(mem_addr_in), .mem_val_in(mem_val_in), .store_len_in(store_len_in),
    .mem_done_out(mem_done_out), .mem_val_read_out(mem_val_read_out),
    .busy_out(busy_out), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  logic [7:0]  ram     [0:262143];
  logic [7:0]  ref_mem [0:262143];
  logic [31:0] prev_a = 32'h0;
  logic [31:0] last_load = 32'h0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;

  logic        d_rst = 1'b1, d_if_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0, d_full = 1'b0;
  logic [31:0] d_if_addr = 32'h0, d_mem_addr = 32'h0, d_val = 32'h0;
  logic [2:0]  d_len = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One bus cycle: apply inputs mid-cycle, return the RAM byte addressed last cycle, commit writes.
  task automatic step();
    @(negedge clk_in);
    cyc++;
    rst_in = d_rst; if_req_in = d_if_req; if_addr_in = d_if_addr;
    read_req_in = d_rd; write_req_in = d_wr; mem_addr_in = d_mem_addr;
    mem_val_in = d_val; store_len_in = d_len; io_buffer_full = d_full;
    mem_din = ram[prev_a[17:0]];
    #1;
    if (mem_wr === 1'b1) ram[mem_a[17:0]] = mem_dout;
    prev_a = mem_a;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_out), 32'h0);
    chk({tag, "_mem_a"}, mem_a, 32'h0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
    chk({tag, "_if_done"}, 32'(if_done_out), 32'h0);
    chk({tag, "_mem_done"}, 32'(mem_done_out), 32'h0);
    chk({tag, "_if_inst"}, if_inst_out, 32'h0);
    chk({tag, "_mem_val"}, mem_val_read_out, 32'h0);
  endtask

  // Mem-stage transaction of n bytes; request is presented in the first step (cycle 0).
  task automatic run_mem(input bit is_wr, input logic [31:0] addr, input int n,
                         input logic [31:0] val, input int stalls);
    logic [31:0] exp_v, ai;
    int st, d;
    bit io;
    io = (addr[17:16] == 2'b11);
    st = (is_wr && io) ? stalls : 0;
    exp_v = 32'h0;
    for (int i = 0; i < n; i++) begin
      ai = addr + 32'(i);
      if (is_wr) ref_mem[ai[17:0]] = val[8*i +: 8];
      else exp_v[8*i +: 8] = ref_mem[ai[17:0]];
    end
    d = is_wr ? n + 1 + st : n + 2;
    d_rd = !is_wr; d_wr = is_wr; d_mem_addr = addr; d_val = val;
    d_len = 3'(is_wr ? n - 1 : n); d_full = 1'b0;
    step();
    d_rd = 1'b0; d_wr = 1'b0;
    for (int c = 1; c <= d + 1; c++) begin
      d_full = io ? 1'(c <= stalls) : 1'($urandom);
      step();
      chk("mem_done", 32'(mem_done_out), 32'(c == d));
      chk("no_if_done", 32'(if_done_out), 32'h0);
      chk("mem_busy", 32'(busy_out), (c < d) ? 32'h2 : 32'h0);
      if (is_wr) begin
        if (c > st && c <= st + n) begin
          int i;
          i = c - st - 1;
          ai = addr + 32'(i);
          chk("wr_strobe", 32'(mem_wr), 32'h1);
          chk("wr_addr", mem_a, ai);
          chk("wr_data", 32'(mem_dout), 32'(val[8*i +: 8]));
        end else begin
          chk("wr_idle", 32'(mem_wr), 32'h0);
        end
      end else begin
        chk("rd_no_wr", 32'(mem_wr), 32'h0);
        if (c <= n) chk("rd_addr", mem_a, addr + 32'(c - 1));
        if (c >= d) chk("load_val", mem_val_read_out, exp_v);
      end
    end
    d_full = 1'b0;
    if (!is_wr) last_load = exp_v;
  endtask

  // Fetch of 4 bytes; with already=1 the request was accepted in the step just taken.
  task automatic run_if(input logic [31:0] addr, input bit already);
    logic [31:0] exp_v, ai;
    for (int i = 0; i < 4; i++) begin
      ai = addr + 32'(i);
      exp_v[8*i +: 8] = ref_mem[ai[17:0]];
    end
    if (!already) begin
      d_if_req = 1'b1; d_if_addr = addr;
      step();
    end
    for (int c = 1; c <= 7; c++) begin
      step();
      chk("if_done", 32'(if_done_out), 32'(c == 6));
      chk("if_busy", 32'(busy_out), (c < 6) ? 32'h1 : 32'h0);
      chk("if_no_mem_done", 32'(mem_done_out), 32'h0);
      chk("if_no_wr", 32'(mem_wr), 32'h0);
      if (c <= 4) chk("fetch_addr", mem_a, addr + 32'(c - 1));
      if (c == 6) begin
        chk("if_inst", if_inst_out, exp_v);
        chk("load_hold", mem_val_read_out, last_load);
        d_if_req = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    for (int i = 32'h100; i < 32'h104; i++) ref_mem[i] = ram[i];

    // Power-on reset
    step(); step();
    d_rst = 1'b0;
    step();
    chk_all_zero("reset");

    // LW 0x100 -> 0x44332211 in cycle 6
    run_mem(1'b0, 32'h100, 4, 32'h0, 0);
    // SH: DD@0x200, CC@0x201, done in cycle 3
    run_mem(1'b1, 32'h200, 2, 32'hAABBCCDD, 0);
    chk("sh_byte0", 32'(ram[32'h200]), 32'hDD);
    chk("sh_byte1", 32'(ram[32'h201]), 32'hCC);

    // Fetch and load requested together: load first, then fetch
    d_if_req = 1'b1; d_if_addr = 32'h1040;
    run_mem(1'b0, 32'h100, 4, 32'h0, 0);
    run_if(32'h1040, 1'b1);

    // Load arriving in cycle 2 of a fetch aborts it; fetch restarts afterwards
    d_if_req = 1'b1; d_if_addr = 32'h1080;
    step();
    step();
    chk("pre_busy", 32'(busy_out), 32'h1);
    chk("pre_addr", mem_a, 32'h1080);
    run_mem(1'b0, 32'h200, 2, 32'h0, 0);
    run_if(32'h1080, 1'b1);

    // SB into IO space with the buffer full for 3 cycles
    run_mem(1'b1, 32'h30000, 1, 32'h0000005A, 3);

    // Reset in the middle of a LW
    d_rd = 1'b1; d_mem_addr = 32'h100; d_len = 3'd4;
    step();
    d_rd = 1'b0;
    step(); step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_all_zero("mid_reset");
    end
    last_load = 32'h0;
    run_mem(1'b0, 32'h102, 1, 32'h0, 0);

    // Randomized mix of fetches, loads and stores
    for (int t = 0; t < 30; t++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 6);
      a = ($urandom_range(0, 3) == 0) ? 32'h30000 + 32'($urandom_range(0, 255))
                                      : 32'h1000 + 32'($urandom_range(0, 255));
      case (kind)
        0: run_if(a, 1'b0);
        1: run_mem(1'b0, a, 1, 32'h0, 0);
        2: run_mem(1'b0, a, 2, 32'h0, 0);
        3: run_mem(1'b0, a, 4, 32'h0, 0);
        4: run_mem(1'b1, a, 1, $urandom, $urandom_range(0, 3));
        5: run_mem(1'b1, a, 2, $urandom, $urandom_range(0, 3));
        default: run_mem(1'b1, a, 4, $urandom, $urandom_range(0, 3));
      endcase
    end

    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < 262144; i++) if (ram[i] !== ref_mem[i]) diffs++;
      chk("ram_image", 32'(diffs), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
